// File: rtl/stream_downsize_if.sv
// -----------------------------------------------------------------------------
// stream_downsize_if
//   Bundles both handshakes of the stream downsizer.
//   Wide side  : s_data_i[lane], s_keep_i, s_last_i, s_valid_i -> s_ready_o
//   Narrow side: m_data_o, m_last_o, m_valid_o                 <- m_ready_i
//   modport slave  : the downsizer's view (consumes wide beats, drives words)
//   modport master : the surrounding logic's view (producer plus consumer)
// -----------------------------------------------------------------------------
interface stream_downsize_if #(
  parameter int T_DATA_WIDTH = 1,
  parameter int T_DATA_RATIO = 2
);
  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO];
  logic [T_DATA_RATIO-1:0] s_keep_i;
  logic                    s_last_i;
  logic                    s_valid_i;
  logic                    s_ready_o;
  logic [T_DATA_WIDTH-1:0] m_data_o;
  logic                    m_last_o;
  logic                    m_valid_o;
  logic                    m_ready_i;

  modport slave (
    input  s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_last_o, m_valid_o
  );

  modport master (
    output s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_last_o, m_valid_o
  );
endinterface

// File: rtl/stream_downsize.sv
// -----------------------------------------------------------------------------
// stream_downsize
//   Captures one wide keep-qualified beat of T_DATA_RATIO lanes and emits the
//   kept lanes one word per cycle, lowest lane first. Lanes with keep=0 are
//   skipped; m_last_o marks the final kept word of a last beat.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : stream_downsize_if.slave (wide slave side + narrow master side)
//   s_ready_o depends combinationally on m_ready_i so a new beat loads in the
//   same cycle the previous beat's final word leaves; the consumer must not
//   derive m_ready_i from s_ready_o.
// -----------------------------------------------------------------------------
module stream_downsize #(
  parameter int T_DATA_WIDTH = 1,
  parameter int T_DATA_RATIO = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  stream_downsize_if.slave  bus
);
  localparam int SEL_W = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;

  // State is not stored separately: it is fully implied by the remaining mask.
  typedef enum logic {EMPTY, DRAIN} state_e;

  logic [T_DATA_WIDTH-1:0] hold_data_q [T_DATA_RATIO];
  logic [T_DATA_WIDTH-1:0] hold_data_d [T_DATA_RATIO];
  logic [T_DATA_RATIO-1:0] rem_q, rem_d;
  logic                    hold_last_q, hold_last_d;

  state_e                  state;
  logic [SEL_W-1:0]        sel;
  logic                    rem_onehot;
  logic                    s_hs;
  logic                    m_hs;

  assign state = (rem_q == '0) ? EMPTY : DRAIN;

  // Priority encoder: lowest set bit of rem wins (scan from the top down so
  // the last assignment is the lowest index).
  always_comb begin
    sel = '0;
    for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
      if (rem_q[i]) sel = SEL_W'(i);
    end
  end

  assign rem_onehot = (state == DRAIN) &&
                      ((rem_q & (rem_q - T_DATA_RATIO'(1))) == '0);

  assign bus.m_valid_o = (state == DRAIN);
  assign bus.m_data_o  = (state == DRAIN) ? hold_data_q[sel] : '0;
  assign bus.m_last_o  = hold_last_q && rem_onehot;
  assign bus.s_ready_o = rst_n && ((state == EMPTY) || (bus.m_ready_i && rem_onehot));

  assign s_hs = bus.s_valid_i && bus.s_ready_o;
  assign m_hs = bus.m_valid_o && bus.m_ready_i;

  // NOTE: every variable gets its hold value first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    hold_data_d = hold_data_q;
    rem_d       = rem_q;
    hold_last_d = hold_last_q;
    if (s_hs) begin
      // A load replaces the mask outright, which also retires the word that
      // leaves in this same cycle.
      hold_data_d = bus.s_data_i;
      rem_d       = bus.s_keep_i;
      hold_last_d = bus.s_last_i;
    end else if (m_hs) begin
      rem_d[sel] = 1'b0;
    end
  end

  // NOTE: the holding array is reset along with the control state so that
  // nothing from before a reset can ever reach m_data_o afterwards.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < T_DATA_RATIO; i++) hold_data_q[i] <= '0;
      rem_q       <= '0;
      hold_last_q <= 1'b0;
    end else begin
      hold_data_q <= hold_data_d;
      rem_q       <= rem_d;
      hold_last_q <= hold_last_d;
    end
  end
endmodule

// File: tb/tb_stream_downsize.sv
// -----------------------------------------------------------------------------
// tb_stream_downsize
//   Scoreboard bench for stream_downsize (T_DATA_WIDTH=8, T_DATA_RATIO=4).
//   The driver pushes the expected narrow words when a wide beat handshakes;
//   an independent monitor pops and compares on every narrow handshake and
//   also checks that a stalled word holds steady.
// -----------------------------------------------------------------------------
module tb_stream_downsize;
  localparam int W = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_downsize_if #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) bus ();

  stream_downsize #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } word_t;

  word_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    words_seen = 0;
  bit    rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected words of one wide beat: kept lanes ascending, last on the top kept lane.
  function automatic void push_expected(input logic [R*W-1:0] d, input logic [R-1:0] keep,
                                        input logic last);
    int    top = -1;
    word_t w;
    for (int i = 0; i < R; i++) if (keep[i]) top = i;
    for (int i = 0; i < R; i++) begin
      if (keep[i]) begin
        w.data = d[i*W +: W];
        w.last = last && (i == top);
        exp_q.push_back(w);
      end
    end
  endfunction

  // Called and returns just after a rising edge.
  task automatic send_beat(input logic [R*W-1:0] d, input logic [R-1:0] keep, input logic last);
    logic hs;
    int   n = 0;
    for (int i = 0; i < R; i++) bus.s_data_i[i] = d[i*W +: W];
    bus.s_keep_i  = keep;
    bus.s_last_i  = last;
    bus.s_valid_i = 1'b1;
    do begin
      @(negedge clk);
      hs = bus.s_ready_o;
      if (hs) push_expected(d, keep, last);
      n++;
      step();
    end while (!hs && n < 200);
    if (!hs) check("send_timeout", 32'(hs), 32'd1);
    bus.s_valid_i = 1'b0;
  endtask

  // Consumer ready: always 1 in directed phases, coin-flip in the random phase.
  always @(posedge clk) begin
    #1;
    bus.m_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor / scoreboard.
  word_t stall_w;
  bit    stalled = 1'b0;
  always @(negedge clk) begin
    word_t e;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 32'(bus.m_valid_o), 32'd1);
        check("stall_data", 32'(bus.m_data_o), 32'(stall_w.data));
        check("stall_last", 32'(bus.m_last_o), 32'(stall_w.last));
      end
      if (bus.m_valid_o && bus.m_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(bus.m_valid_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("word_data", 32'(bus.m_data_o), 32'(e.data));
          check("word_last", 32'(bus.m_last_o), 32'(e.last));
          words_seen++;
        end
      end
      stalled      = bus.m_valid_o && !bus.m_ready_i;
      stall_w.data = bus.m_data_o;
      stall_w.last = bus.m_last_o;
    end
  end

  initial begin
    int n;
    int w0;
    int v;

    // ---------------- reset with a pending (zero-keep) beat ----------------
    for (int i = 0; i < R; i++) bus.s_data_i[i] = 8'h77;
    bus.s_keep_i  = '0;
    bus.s_last_i  = 1'b1;
    bus.s_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(bus.s_ready_o), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid_o), 32'd0);
    check("rst_m_last", 32'(bus.m_last_o), 32'd0);
    check("rst_m_data", 32'(bus.m_data_o), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.s_ready_o), 32'd1);
    step();
    bus.s_valid_i = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'(bus.m_valid_o), 32'd0);
    step();

    // ---------------- full beat: 11,22,33,44 ----------------
    w0 = words_seen;
    send_beat(32'h44332211, 4'b1111, 1'b1);
    repeat (4) step();
    check("full_count", 32'(words_seen - w0), 32'd4);
    check("full_idle", 32'(bus.m_valid_o), 32'd0);

    // ---------------- sparse keep, then all-zero keep ----------------
    send_beat(32'hAAC3BB5A, 4'b1010, 1'b1);
    $display("warning: sending zero-keep beat (upstream protocol violation, last dropped)");
    send_beat(32'h12345678, 4'b0000, 1'b1);
    @(negedge clk);
    check("zero_keep_no_output", 32'(bus.m_valid_o), 32'd0);
    check("zero_keep_ready", 32'(bus.s_ready_o), 32'd1);
    check("sparse_drained", 32'(exp_q.size()), 32'd0);
    step();

    // ---------------- back-to-back: three 2-word beats ----------------
    fork
      begin
        send_beat(32'h00000201, 4'b0011, 1'b0);
        send_beat(32'h00000403, 4'b0011, 1'b0);
        send_beat(32'h00000605, 4'b0011, 1'b1);
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.m_valid_o && n < 20);
        for (int k = 0; k < 6; k++) begin
          if (k > 0) @(negedge clk);
          check("b2b_valid", 32'(bus.m_valid_o), 32'd1);
          check("b2b_ready", 32'(bus.s_ready_o), 32'(k % 2));
        end
        @(negedge clk);
        check("b2b_idle", 32'(bus.m_valid_o), 32'd0);
      end
    join
    step();

    // ---------------- random backpressure, 200 beats ----------------
    rand_ready = 1'b1;
    for (int b = 0; b < 200; b++) begin
      send_beat($urandom, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check("random_drained", 32'(exp_q.size()), 32'd0);
    step();

    // ---------------- reset mid-drain ----------------
    send_beat(32'hDDCCBBAA, 4'b1111, 1'b1);
    step();
    check("mid_valid", 32'(bus.m_valid_o), 32'd1);
    check("mid_data", 32'(bus.m_data_o), 32'hBB);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.m_valid_o), 32'd0);
    check("mid_rst_data", 32'(bus.m_data_o), 32'd0);
    check("mid_rst_ready", 32'(bus.s_ready_o), 32'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    v = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.m_valid_o) v++;
    end
    check("no_words_after_reset", 32'(v), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
